// File: rtl/game_pkg.sv
// Shared shooter-core definitions: game states, object counts, index widths
// and the enemy fire scheduler's state encoding plus reload helper.
package game_pkg;

    typedef enum logic [2:0] {
        GS_IDLE    = 3'd0,
        GS_PLAYING = 3'd1,
        GS_VICTORY = 3'd2,
        GS_DEFEAT  = 3'd3,
        GS_ERROR   = 3'd4
    } game_state_e;

    localparam int unsigned MAX_ENEMY         = 15;
    localparam int unsigned MAX_ENEMY_BULLET  = 31;
    localparam int unsigned MAX_PLAYER_BULLET = 8;

    localparam int unsigned ENEMY_IDX_W   = 4;
    localparam int unsigned EBULLET_IDX_W = 5;
    localparam int unsigned PHASE_W       = 2;
    localparam int unsigned COUNT_W       = 8;
    localparam int unsigned SHOT_W        = 8;

    localparam logic [COUNT_W-1:0] FIRE_PERIOD_DEFAULT = 8'd48;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_PICK  = 2'd2,
        S_ISSUE = 2'd3
    } fire_state_e;

    // Fire period shortened by stage phase, never below one tick.
    function automatic logic [COUNT_W-1:0] reload_value(
        input logic [COUNT_W-1:0] period,
        input logic [PHASE_W-1:0] phase
    );
        logic [COUNT_W-1:0] v;
        v = period >> phase;
        return (v == '0) ? COUNT_W'(1) : v;
    endfunction

endpackage

// File: rtl/enemy_fire_scheduler_if.sv
// Spawn offer handshake between the fire scheduler and the game datapath.
interface enemy_fire_scheduler_if;
    import game_pkg::*;

    logic                     o_SpawnValid;
    logic [ENEMY_IDX_W-1:0]   o_SpawnEnemy;
    logic [EBULLET_IDX_W-1:0] o_SpawnSlot;
    logic                     i_SpawnAck;

    modport master (
        output o_SpawnValid,
        output o_SpawnEnemy,
        output o_SpawnSlot,
        input  i_SpawnAck
    );

    modport slave (
        input  o_SpawnValid,
        input  o_SpawnEnemy,
        input  o_SpawnSlot,
        output i_SpawnAck
    );
endinterface

// File: rtl/rr_priority_pick.sv
// Rotating priority picker: first set request bit at or after i_Start,
// wrapping from N-1 back to 0.
module rr_priority_pick #(
    parameter int unsigned N = 15,
    parameter int unsigned W = 4
) (
    input  logic [N-1:0] i_Req,
    input  logic [W-1:0] i_Start,
    output logic         o_Found_c,
    output logic [W-1:0] o_Index_c
);
    localparam int unsigned PW = W + 1;

    logic [W:0] w_pos;

    always_comb begin
        o_Found_c = 1'b0;
        o_Index_c = '0;
        w_pos     = '0;
        for (int unsigned i = 0; i < N; i++) begin
            w_pos = PW'(i) + {1'b0, i_Start};
            if (w_pos >= PW'(N)) begin
                w_pos = w_pos - PW'(N);
            end
            if (!o_Found_c && i_Req[w_pos[W-1:0]]) begin
                o_Found_c = 1'b1;
                o_Index_c = w_pos[W-1:0];
            end
        end
    end

endmodule

// File: rtl/enemy_fire_scheduler.sv
// Periodic enemy shot scheduler: round-robin shooter, lowest free bullet slot,
// offered to the datapath over a valid/ack handshake.
module enemy_fire_scheduler
    import game_pkg::*;
#(
    parameter logic [COUNT_W-1:0] FIRE_PERIOD = FIRE_PERIOD_DEFAULT
) (
    input  logic                        i_Clock,
    input  logic                        i_Reset,
    input  logic                        i_Tick,
    input  logic                        i_Enable,
    input  logic [PHASE_W-1:0]          i_PhaseState,
    input  logic [MAX_ENEMY-1:0]        i_EnemyState,
    input  logic [MAX_ENEMY_BULLET-1:0] i_EnemyBulletState,
    enemy_fire_scheduler_if.master      io_Spawn,
    output logic                        o_Stall,
    output logic [SHOT_W-1:0]           o_ShotCount
);
    localparam logic [ENEMY_IDX_W-1:0] LAST_INIT = ENEMY_IDX_W'(MAX_ENEMY - 1);

    fire_state_e              r_state, w_state_n;
    logic [COUNT_W-1:0]       r_count, w_count_n;
    logic [ENEMY_IDX_W-1:0]   r_last, w_last_n;
    logic                     r_valid, w_valid_n;
    logic [ENEMY_IDX_W-1:0]   r_enemy, w_enemy_n;
    logic [EBULLET_IDX_W-1:0] r_slot, w_slot_n;
    logic                     r_stall, w_stall_n;
    logic [SHOT_W-1:0]        r_shot, w_shot_n;

    logic [COUNT_W-1:0]          w_reload;
    logic [ENEMY_IDX_W-1:0]      w_start;
    logic [MAX_ENEMY_BULLET-1:0] w_slot_free;
    logic                        w_enemy_found, w_slot_found;
    logic [ENEMY_IDX_W-1:0]      w_enemy_idx;
    logic [EBULLET_IDX_W-1:0]    w_slot_idx;

    assign w_reload    = reload_value(FIRE_PERIOD, i_PhaseState);
    assign w_start     = (r_last >= LAST_INIT) ? '0 : r_last + ENEMY_IDX_W'(1);
    assign w_slot_free = ~i_EnemyBulletState;

    rr_priority_pick #(.N(MAX_ENEMY), .W(ENEMY_IDX_W)) u_enemy_pick (
        .i_Req     (i_EnemyState),
        .i_Start   (w_start),
        .o_Found_c (w_enemy_found),
        .o_Index_c (w_enemy_idx)
    );

    rr_priority_pick #(.N(MAX_ENEMY_BULLET), .W(EBULLET_IDX_W)) u_slot_pick (
        .i_Req     (w_slot_free),
        .i_Start   (EBULLET_IDX_W'(0)),
        .o_Found_c (w_slot_found),
        .o_Index_c (w_slot_idx)
    );

    always_ff @(posedge i_Clock or negedge i_Reset) begin
        if (!i_Reset) begin
            r_state <= S_IDLE;
            r_count <= '0;
            r_last  <= LAST_INIT;
            r_valid <= 1'b0;
            r_enemy <= '0;
            r_slot  <= '0;
            r_stall <= 1'b0;
            r_shot  <= '0;
        end else begin
            r_state <= w_state_n;
            r_count <= w_count_n;
            r_last  <= w_last_n;
            r_valid <= w_valid_n;
            r_enemy <= w_enemy_n;
            r_slot  <= w_slot_n;
            r_stall <= w_stall_n;
            r_shot  <= w_shot_n;
        end
    end

    // Next state; losing enable withdraws any offer without counting it.
    always_comb begin
        w_state_n = r_state;
        w_count_n = r_count;
        w_last_n  = r_last;
        w_valid_n = r_valid;
        w_enemy_n = r_enemy;
        w_slot_n  = r_slot;
        w_stall_n = 1'b0;
        w_shot_n  = r_shot;
        if (!i_Enable) begin
            w_state_n = S_IDLE;
            w_valid_n = 1'b0;
            if (r_state == S_IDLE) begin
                w_count_n = '0;
                w_last_n  = LAST_INIT;
                w_shot_n  = '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_n = S_WAIT;
                    w_count_n = w_reload;
                    w_last_n  = LAST_INIT;
                    w_shot_n  = '0;
                    w_valid_n = 1'b0;
                end
                S_WAIT: begin
                    if (i_Tick) begin
                        if (r_count <= COUNT_W'(1)) begin
                            w_state_n = S_PICK;
                        end else begin
                            w_count_n = r_count - COUNT_W'(1);
                        end
                    end
                end
                S_PICK: begin
                    if (!w_enemy_found) begin
                        w_state_n = S_WAIT;
                        w_count_n = w_reload;
                    end else if (!w_slot_found) begin
                        w_stall_n = 1'b1;
                    end else begin
                        w_state_n = S_ISSUE;
                        w_enemy_n = w_enemy_idx;
                        w_slot_n  = w_slot_idx;
                        w_valid_n = 1'b1;
                    end
                end
                S_ISSUE: begin
                    if (io_Spawn.i_SpawnAck) begin
                        w_state_n = S_WAIT;
                        w_valid_n = 1'b0;
                        w_last_n  = r_enemy;
                        w_count_n = w_reload;
                        w_shot_n  = (r_shot != '1) ? r_shot + SHOT_W'(1) : r_shot;
                    end
                end
                default: begin
                    w_state_n = S_IDLE;
                    w_valid_n = 1'b0;
                end
            endcase
        end
    end

    assign io_Spawn.o_SpawnValid = r_valid;
    assign io_Spawn.o_SpawnEnemy = r_enemy;
    assign io_Spawn.o_SpawnSlot  = r_slot;
    assign o_Stall               = r_stall;
    assign o_ShotCount           = r_shot;

endmodule

// File: tb/tb_enemy_fire_scheduler.sv
// Bench for enemy_fire_scheduler: directed scenarios plus randomized shots
// checked against a transaction-level model of period, round-robin and slot choice.
module tb_enemy_fire_scheduler;
    import game_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        tick;
    logic        en;
    logic [1:0]  phase;
    logic [14:0] alive;
    logic [30:0] bullets;
    logic        stall_a, stall_b;
    logic [7:0]  shot_a, shot_b;

    int errors = 0;
    int checks = 0;
    int cycle_ctr = 0;
    int m_last = 14;
    int m_shot = 0;

    enemy_fire_scheduler_if if_a();
    enemy_fire_scheduler_if if_b();

    enemy_fire_scheduler u_dut (
        .i_Clock            (clk),
        .i_Reset            (rst_n),
        .i_Tick             (tick),
        .i_Enable           (en),
        .i_PhaseState       (phase),
        .i_EnemyState       (alive),
        .i_EnemyBulletState (bullets),
        .io_Spawn           (if_a),
        .o_Stall            (stall_a),
        .o_ShotCount        (shot_a)
    );

    enemy_fire_scheduler #(.FIRE_PERIOD(8'd2)) u_dut_clamp (
        .i_Clock            (clk),
        .i_Reset            (rst_n),
        .i_Tick             (tick),
        .i_Enable           (en),
        .i_PhaseState       (phase),
        .i_EnemyState       (alive),
        .i_EnemyBulletState (bullets),
        .io_Spawn           (if_b),
        .o_Stall            (stall_b),
        .o_ShotCount        (shot_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        cycle_ctr <= cycle_ctr + 1;
        if (cycle_ctr > 60000) begin
            $display("FAIL watchdog: cycles=%0d limit=60000", cycle_ctr);
            $fatal(1);
        end
    end

    // Reference rules
    function automatic int m_reload(input int period, input int ph);
        int v;
        v = period;
        for (int i = 0; i < ph; i++) v = v / 2;
        return (v < 1) ? 1 : v;
    endfunction

    function automatic int m_pick_enemy(input logic [14:0] mask, input int last);
        for (int d = 1; d <= 15; d++) begin
            if (mask[(last + d) % 15]) return (last + d) % 15;
        end
        return -1;
    endfunction

    function automatic int m_pick_slot(input logic [30:0] mask);
        for (int s = 0; s < 31; s++) begin
            if (!mask[s]) return s;
        end
        return -1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fire_ticks(input int n, input int gap_max);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(gap_max, 0)) step();
            tick = 1'b1;
            step();
            tick = 1'b0;
        end
    endtask

    task automatic wait_valid(input bit sel, input int max_cyc, output int cyc);
        cyc = 0;
        while (((sel ? if_b.o_SpawnValid : if_a.o_SpawnValid) !== 1'b1) && cyc < max_cyc) begin
            step();
            cyc++;
        end
    endtask

    task automatic test_reset();
        en = 0; tick = 0; phase = 0; alive = '1; bullets = '0;
        if_a.i_SpawnAck = 0; if_b.i_SpawnAck = 0;
        rst_n = 0;
        step(); step();
        checks++; if (if_a.o_SpawnValid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", if_a.o_SpawnValid); end
        checks++; if (if_a.o_SpawnEnemy !== 4'd0) begin errors++; $display("FAIL reset_enemy got=%0d exp=0", if_a.o_SpawnEnemy); end
        checks++; if (if_a.o_SpawnSlot !== 5'd0) begin errors++; $display("FAIL reset_slot got=%0d exp=0", if_a.o_SpawnSlot); end
        checks++; if (stall_a !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", stall_a); end
        checks++; if (shot_a !== 8'd0) begin errors++; $display("FAIL reset_shot got=%0d exp=0", shot_a); end
        rst_n = 1;
        step();
    endtask

    task automatic test_basic();
        int r, cyc, exp_e;
        en = 1; phase = 0; alive = '1; bullets = '0; if_a.i_SpawnAck = 1;
        step();
        m_last = 14; m_shot = 0;
        r = m_reload(48, 0);
        for (int k = 0; k < 2; k++) begin
            fire_ticks(r - 1, 1);
            repeat (3) step();
            checks++; if (if_a.o_SpawnValid !== 1'b0) begin errors++; $display("FAIL basic_early shot=%0d got=%b exp=0", k, if_a.o_SpawnValid); end
            fire_ticks(1, 0);
            wait_valid(1'b0, 4, cyc);
            exp_e = m_pick_enemy(alive, m_last);
            checks++; if (cyc !== 1) begin errors++; $display("FAIL basic_latency shot=%0d got=%0d exp=1", k, cyc); end
            checks++; if (int'(if_a.o_SpawnEnemy) !== exp_e) begin errors++; $display("FAIL basic_enemy shot=%0d got=%0d exp=%0d", k, if_a.o_SpawnEnemy, exp_e); end
            checks++; if (int'(if_a.o_SpawnSlot) !== m_pick_slot(bullets)) begin errors++; $display("FAIL basic_slot got=%0d exp=%0d", if_a.o_SpawnSlot, m_pick_slot(bullets)); end
            step();
            m_last = exp_e; m_shot++;
            checks++; if (if_a.o_SpawnValid !== 1'b0) begin errors++; $display("FAIL basic_ack_drop got=%b exp=0", if_a.o_SpawnValid); end
        end
        checks++; if (int'(shot_a) !== m_shot) begin errors++; $display("FAIL basic_shotcount got=%0d exp=%0d", shot_a, m_shot); end
    endtask

    task automatic test_round_robin_phase();
        int r, cyc, exp_e;
        alive = 15'b000_0000_0010_0100;
        phase = 3;
        // running count was loaded with phase 0
        fire_ticks(47, 0);
        repeat (2) step();
        checks++; if (if_a.o_SpawnValid !== 1'b0) begin errors++; $display("FAIL phase_midcount got=%b exp=0", if_a.o_SpawnValid); end
        fire_ticks(1, 0);
        r = m_reload(48, 3);
        for (int k = 0; k < 3; k++) begin
            if (k > 0) begin
                fire_ticks(r - 1, 1);
                step();
                checks++; if (if_a.o_SpawnValid !== 1'b0) begin errors++; $display("FAIL phase3_early shot=%0d got=%b exp=0", k, if_a.o_SpawnValid); end
                fire_ticks(1, 0);
            end
            wait_valid(1'b0, 4, cyc);
            exp_e = m_pick_enemy(alive, m_last);
            checks++; if (cyc !== 1) begin errors++; $display("FAIL rr_latency shot=%0d got=%0d exp=1", k, cyc); end
            checks++; if (int'(if_a.o_SpawnEnemy) !== exp_e) begin errors++; $display("FAIL rr_enemy shot=%0d got=%0d exp=%0d", k, if_a.o_SpawnEnemy, exp_e); end
            step();
            m_last = exp_e; m_shot++;
        end
        checks++; if (int'(shot_a) !== m_shot) begin errors++; $display("FAIL rr_shotcount got=%0d exp=%0d", shot_a, m_shot); end
    endtask

    task automatic test_stall_hold_withdraw();
        int cyc, exp_e, exp_s, bad;
        alive = '1; bullets = '1; if_a.i_SpawnAck = 0;
        fire_ticks(m_reload(48, 3), 0);
        step();
        checks++; if (stall_a !== 1'b1) begin errors++; $display("FAIL stall_set got=%b exp=1", stall_a); end
        repeat (3) step();
        checks++; if (stall_a !== 1'b1 || if_a.o_SpawnValid !== 1'b0) begin errors++; $display("FAIL stall_hold stall=%b valid=%b exp=1/0", stall_a, if_a.o_SpawnValid); end
        bullets[7] = 1'b0;
        wait_valid(1'b0, 4, cyc);
        exp_e = m_pick_enemy(alive, m_last);
        exp_s = m_pick_slot(bullets);
        checks++; if (cyc < 1 || cyc > 2) begin errors++; $display("FAIL stall_release_latency got=%0d exp=1..2", cyc); end
        checks++; if (int'(if_a.o_SpawnSlot) !== exp_s || int'(if_a.o_SpawnEnemy) !== exp_e) begin errors++; $display("FAIL stall_release_pick slot=%0d/%0d enemy=%0d/%0d", if_a.o_SpawnSlot, exp_s, if_a.o_SpawnEnemy, exp_e); end
        checks++; if (stall_a !== 1'b0) begin errors++; $display("FAIL stall_clear got=%b exp=0", stall_a); end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            alive = 15'($urandom);
            step();
            if (if_a.o_SpawnValid !== 1'b1 || int'(if_a.o_SpawnEnemy) !== exp_e || int'(if_a.o_SpawnSlot) !== exp_s) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL hold_stable bad_cycles=%0d exp=0", bad); end
        en = 0;
        step();
        checks++; if (if_a.o_SpawnValid !== 1'b0) begin errors++; $display("FAIL withdraw_valid got=%b exp=0", if_a.o_SpawnValid); end
        checks++; if (int'(shot_a) !== m_shot) begin errors++; $display("FAIL withdraw_count got=%0d exp=%0d", shot_a, m_shot); end
        step();
        m_shot = 0;
        checks++; if (int'(shot_a) !== m_shot) begin errors++; $display("FAIL idle_clear got=%0d exp=%0d", shot_a, m_shot); end
    endtask

    task automatic test_no_enemy_and_async_reset();
        int r, cyc, exp_e;
        en = 1; alive = '0; bullets = '0; if_a.i_SpawnAck = 0;
        step();
        m_last = 14;
        r = m_reload(48, int'(phase));
        fire_ticks(r, 0);
        repeat (3) step();
        checks++; if (if_a.o_SpawnValid !== 1'b0 || stall_a !== 1'b0) begin errors++; $display("FAIL noenemy_idle valid=%b stall=%b exp=0/0", if_a.o_SpawnValid, stall_a); end
        alive = 15'b000_0010_0000_0000;
        fire_ticks(r - 1, 0);
        step();
        checks++; if (if_a.o_SpawnValid !== 1'b0) begin errors++; $display("FAIL noenemy_reload_early got=%b exp=0", if_a.o_SpawnValid); end
        fire_ticks(1, 0);
        wait_valid(1'b0, 4, cyc);
        exp_e = m_pick_enemy(alive, m_last);
        checks++; if (cyc !== 1 || int'(if_a.o_SpawnEnemy) !== exp_e) begin errors++; $display("FAIL noenemy_reload_pick cyc=%0d enemy=%0d exp=1/%0d", cyc, if_a.o_SpawnEnemy, exp_e); end
        #3;
        rst_n = 0;
        #1;
        checks++; if (if_a.o_SpawnValid !== 1'b0 || if_a.o_SpawnEnemy !== 4'd0 || if_a.o_SpawnSlot !== 5'd0 || stall_a !== 1'b0 || shot_a !== 8'd0) begin
            errors++;
            $display("FAIL async_reset valid=%b enemy=%0d slot=%0d stall=%b shot=%0d exp=all 0", if_a.o_SpawnValid, if_a.o_SpawnEnemy, if_a.o_SpawnSlot, stall_a, shot_a);
        end
        step();
        rst_n = 1;
        step();
    endtask

    task automatic test_clamp();
        int r, cyc, exp_e, last_b;
        en = 0; step();
        en = 1; phase = 3; alive = '1; bullets = '0; if_b.i_SpawnAck = 1;
        step();
        last_b = 14;
        r = m_reload(2, 3);
        for (int k = 0; k < 4; k++) begin
            fire_ticks(r, 0);
            wait_valid(1'b1, 4, cyc);
            exp_e = m_pick_enemy(alive, last_b);
            checks++; if (cyc !== 1 || int'(if_b.o_SpawnEnemy) !== exp_e) begin errors++; $display("FAIL clamp_shot k=%0d cyc=%0d enemy=%0d exp=1/%0d", k, cyc, if_b.o_SpawnEnemy, exp_e); end
            step();
            last_b = exp_e;
        end
        checks++; if (shot_b !== 8'd4) begin errors++; $display("FAIL clamp_shotcount got=%0d exp=4", shot_b); end
        if_b.i_SpawnAck = 0;
    endtask

    task automatic test_random();
        int cnt, cyc, exp_e, exp_s, bad;
        rst_n = 0; step(); rst_n = 1;
        if_a.i_SpawnAck = 0; tick = 0;
        phase = 2'($urandom_range(3, 0));
        en = 1;
        step();
        m_last = 14; m_shot = 0;
        cnt = m_reload(48, int'(phase));
        for (int n = 0; n < 20; n++) begin
            phase = 2'($urandom_range(3, 0));
            alive = 15'($urandom_range(32767, 1));
            bullets = 31'($urandom);
            if (bullets == '1) bullets[$urandom_range(30, 0)] = 1'b0;
            if (cnt > 1) begin
                fire_ticks(cnt - 1, 2);
                step();
                checks++; if (if_a.o_SpawnValid !== 1'b0) begin errors++; $display("FAIL rand_early n=%0d got=%b exp=0", n, if_a.o_SpawnValid); end
            end
            fire_ticks(1, 1);
            wait_valid(1'b0, 4, cyc);
            exp_e = m_pick_enemy(alive, m_last);
            exp_s = m_pick_slot(bullets);
            checks++; if (cyc !== 1 || int'(if_a.o_SpawnEnemy) !== exp_e || int'(if_a.o_SpawnSlot) !== exp_s) begin
                errors++;
                $display("FAIL rand_offer n=%0d cyc=%0d enemy=%0d slot=%0d exp=1/%0d/%0d", n, cyc, if_a.o_SpawnEnemy, if_a.o_SpawnSlot, exp_e, exp_s);
            end
            bad = 0;
            repeat ($urandom_range(3, 0)) begin
                alive = 15'($urandom);
                step();
                if (if_a.o_SpawnValid !== 1'b1 || int'(if_a.o_SpawnEnemy) !== exp_e || int'(if_a.o_SpawnSlot) !== exp_s) bad++;
            end
            if_a.i_SpawnAck = 1;
            step();
            if_a.i_SpawnAck = 0;
            m_last = exp_e;
            m_shot = (m_shot < 255) ? m_shot + 1 : 255;
            cnt = m_reload(48, int'(phase));
            checks++; if (if_a.o_SpawnValid !== 1'b0 || int'(shot_a) !== m_shot || bad !== 0) begin
                errors++;
                $display("FAIL rand_accept n=%0d valid=%b shot=%0d bad=%0d exp=0/%0d/0", n, if_a.o_SpawnValid, shot_a, bad, m_shot);
            end
        end
    endtask

    initial begin
        rst_n = 0; tick = 0; en = 0; phase = 0; alive = '0; bullets = '0;
        if_a.i_SpawnAck = 0; if_b.i_SpawnAck = 0;
        test_reset();
        test_basic();
        test_round_robin_phase();
        test_stall_hold_withdraw();
        test_no_enemy_and_async_reset();
        test_clamp();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/enemy_fire_scheduler.md
# enemy_fire_scheduler

Schedules enemy shots for the shooter game core. Once per fire period (measured in game ticks, shortened by stage phase) it picks the next live enemy round-robin and the lowest free enemy-bullet slot. It then offers that spawn to the game datapath over a valid/ack handshake. It sits beside the game FSM, consumes its enemy/bullet occupancy masks, and drives its enemy-bullet spawn logic.

## Interface
- MAX_ENEMY, 15, number of enemies (index width 4)
- MAX_ENEMY_BULLET, 31, number of enemy-bullet slots (index width 5)
- FIRE_PERIOD, 8'd48, ticks between shots in phase 0
- i_Clock  in  1  system clock
- i_Reset  in  1  reset, asynchronous, active-low
- i_Tick  in  1  game tick, single-cycle enable synchronous to i_Clock
- i_Enable  in  1  high while game state is PLAYING
- i_PhaseState  in  2  stage phase; reload = FIRE_PERIOD >> phase
- i_EnemyState  in  MAX_ENEMY  alive mask, bit k = enemy k alive
- i_EnemyBulletState  in  MAX_ENEMY_BULLET  occupancy, bit s = slot s in flight
- i_SpawnAck  in  1  datapath has latched the offered spawn
- o_SpawnValid  out  1  spawn offer pending
- o_SpawnEnemy  out  4  shooter index, stable while valid
- o_SpawnSlot  out  5  bullet slot index, stable while valid
- o_Stall  out  1  shot due but no free slot
- o_ShotCount  out  8  accepted spawns since leaving IDLE, saturates at 255

## Operation
- States: S_IDLE, S_WAIT, S_PICK, S_ISSUE.
- S_IDLE:
  - tick counter = 0; last-grant pointer = MAX_ENEMY-1, so the first search starts at enemy 0; o_ShotCount = 0.
  - i_Enable=1 → load counter with reload, go to S_WAIT.
- S_WAIT: on i_Tick, if counter ≤ 1 go to S_PICK, else decrement.
- S_PICK, single clock evaluation:
  - Enemy: first k with i_EnemyState[k]=1, searching from last+1 upward and wrapping at MAX_ENEMY-1 → 0.
  - Slot: lowest s with i_EnemyBulletState[s]=0.
  - No live enemy → reload counter, go to S_WAIT, no spawn.
  - Live enemy but no free slot → stay in S_PICK, o_Stall=1, re-evaluate every clock.
  - Both found → register enemy and slot, go to S_ISSUE.
- S_ISSUE:
  - o_SpawnValid=1; indices held.
  - i_SpawnAck=1 → last-grant pointer = o_SpawnEnemy, o_ShotCount+1 (saturating), reload counter, go to S_WAIT.
- Reload value = max(1, FIRE_PERIOD >> i_PhaseState), sampled at reload time. Phase changes mid-count do not affect the running count.
- i_Enable=0 in any state → S_IDLE next clock. This overrides Ack; a pending offer is withdrawn and not counted.
- Enemy dying while in S_ISSUE does not cancel the offer; the datapath decides.
- i_SpawnAck outside S_ISSUE is ignored.
- i_Tick is ignored in S_PICK and S_ISSUE; ticks are not accumulated.

## Timing
- All outputs are registered. Reset values: o_SpawnValid=0, o_SpawnEnemy=0, o_SpawnSlot=0, o_Stall=0, o_ShotCount=0, state=S_IDLE.
- Tick that expires the count at cycle T → S_PICK during T+1 → o_SpawnValid=1 from T+2.
- Ack at cycle A → o_SpawnValid=0 at A+1. Back-to-back spawns are impossible; the minimum spacing is the reload value in ticks.
- o_Stall is asserted from the clock after entering a stalled S_PICK and clears the clock after a slot frees.
- Reset assertion at any time forces the reset values immediately; the handshake is abandoned.

## Structure
- Shared package game_pkg holds:
  - game-state encodings (IDLE/PLAYING/VICTORY/DEFEAT/ERROR);
  - MAX_ENEMY, MAX_ENEMY_BULLET, MAX_PLAYER_BULLET;
  - index widths;
  - this block's state encoding.
- One sub-module, rr_priority_pick (parameterized width N), shared by enemy selection and reused with a fixed start of 0 for slot selection. Interface:
  - request mask in, start pointer in;
  - found flag out, index out.

## Test plan
- Reset, i_Enable=1, phase 0, all enemies alive, no bullets, Ack tied high → first offer after 48 ticks with enemy 0, slot 0; next offer 48 ticks later with enemy 1. o_ShotCount=2.
- Alive mask 15'b000_0000_0010_0100, last grant 2 → next pick enemy 5, then wraps to enemy 2.
- Phase 3 → spawn every 6 ticks. FIRE_PERIOD=2 with phase 3 → reload clamps to 1, one spawn per tick.
- Bullet mask all ones at expiry → o_Stall=1, no valid. Clear bit 7 → slot 7 offered 2 clocks later, o_Stall=0.
- Hold Ack low 10 clocks in S_ISSUE → indices stable, valid stays high. Drop i_Enable → valid=0 next clock, ShotCount unchanged.
- Alive mask zero at expiry → no offer, counter reloaded. Async reset mid-S_ISSUE → all outputs at reset values immediately.
